// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: turns the raster position from the VGA timing generator
// into framebuffer reads, expands the returned RGB332 pixel to RGB444 and
// delays hsync/vsync so they stay aligned with the colour driven to the DAC.
// Optional build macro VGA_PALETTE_EN replaces the RGB332 expansion with a
// 256x12 palette lookup, adding one pixel of latency to colour and syncs.
module vga_pixel_fetch #(
  parameter int H_OFFSET    = 48,
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
`ifdef VGA_PALETTE_EN
  input  logic              pal_we,
  input  logic [7:0]        pal_waddr,
  input  logic [11:0]       pal_wdata,
`endif
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_rdata,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_start
);

  localparam logic signed [10:0] HOFF_S = 11'(H_OFFSET);
  localparam logic [10:0]        FBW_L  = 11'(FB_WIDTH);
  localparam logic [10:0]        FBH_L  = 11'(FB_HEIGHT);

  logic signed [10:0] col_s_p0;
  logic signed [10:0] col_sh_p0;
  logic [10:0]        col_p0;
  logic [10:0]        row_p0;
  logic               in_range_p0;
  logic               fetch_p0;
  logic [ADDR_W-1:0]  addr_p0;

  logic               vld_p0;
  logic               hs_p0;
  logic               vs_p0;
  logic               cap_pend;
  logic [7:0]         pix_p1;
  logic               fs_armed;

  // S0 address map: a negative column (left border) is out of range
  always_comb begin
    col_s_p0    = $signed({1'b0, x}) - HOFF_S;
    col_sh_p0   = col_s_p0 >>> SCALE_SHIFT;
    col_p0      = $unsigned(col_sh_p0);
    row_p0      = {1'b0, y} >> SCALE_SHIFT;
    in_range_p0 = !col_s_p0[10] && (col_p0 < FBW_L) && (row_p0 < FBH_L);
    fetch_p0    = video_on && in_range_p0;
    addr_p0     = ADDR_W'(row_p0) * ADDR_W'(FB_WIDTH) + ADDR_W'(col_p0);
  end

  // ---- stage S0: issue read, capture sync/visibility into delay stage d0
  always_ff @(posedge clock) begin
    if (reset) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
      vld_p0   <= 1'b0;
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
      cap_pend <= 1'b0;
      pix_p1   <= '0;
    end else begin
      fb_rd_en <= 1'b0;
      if (p_tick) begin
        fb_rd_en <= fetch_p0;
        if (fetch_p0) fb_addr <= addr_p0;
        vld_p0   <= fetch_p0;
        hs_p0    <= hsync_in;
        vs_p0    <= vsync_in;
        cap_pend <= 1'b1;
      end else if (cap_pend) begin
        // ---- capture stage: RAM data is only trusted if a read was issued
        pix_p1   <= fb_rd_en ? fb_rdata : 8'h00;
        cap_pend <= 1'b0;
      end
    end
  end

  // Frame-start pulse; disarmed while x/y sit at the origin so it fires once
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_start <= 1'b0;
      fs_armed    <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      if (p_tick) begin
        if (x == 10'd0 && y == 10'd0) begin
          frame_start <= fs_armed;
          fs_armed    <= 1'b0;
        end else begin
          fs_armed <= 1'b1;
        end
      end
    end
  end

`ifdef VGA_PALETTE_EN
  logic [11:0] palette [256];
  logic [11:0] pal_q_p2;
  logic        vld_p1;
  logic        hs_p1;
  logic        vs_p1;

  // Palette write port; a same-clock read of the written index sees old data
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_waddr] <= pal_wdata;
    end
  end

  // ---- stage S1: palette lookup; stage S2: drive colour and syncs
  always_ff @(posedge clock) begin
    if (reset) begin
      pal_q_p2  <= '0;
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (p_tick) begin
      pal_q_p2  <= palette[pix_p1];
      vld_p1    <= vld_p0;
      hs_p1     <= hs_p0;
      vs_p1     <= vs_p0;
      rgb       <= vld_p1 ? pal_q_p2 : 12'h000;
      hsync_out <= hs_p1;
      vsync_out <= vs_p1;
    end
  end
`else
  // RGB332 -> RGB444 by replicating the top bits into the new low bits
  function automatic logic [11:0] expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  // ---- stage S1: drive colour and syncs together on the next pixel strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (p_tick) begin
      rgb       <= vld_p0 ? expand(pix_p1) : 12'h000;
      hsync_out <= hs_p0;
      vsync_out <= vs_p0;
    end
  end
`endif

endmodule
